// File: rtl/wave_gen.sv
// Multi-mode waveform generator: phase accumulator -> shape -> amplitude scale around DAC midscale.
// Define WAVE_GEN_SYNC_UPDATE_EN to defer loaded settings to the next waveform period boundary.
module wave_gen #(
  parameter int DAC_W  = 14,
  parameter int ACC_W  = 24,
  parameter int FREQ_W = 14,
  parameter int AMP_W  = 8,
  parameter int PH_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [1:0]        mode,
  input  logic [FREQ_W-1:0] state_freq,
  input  logic [AMP_W-1:0]  state_amp,
  input  logic [PH_W-1:0]   state_phase,
  output logic [DAC_W-1:0]  DAC_in,
  output logic              sync
);

  localparam logic [DAC_W-1:0] MID = {1'b1, {(DAC_W-1){1'b0}}};
  localparam int PROD_W = DAC_W + AMP_W + 2;

  function automatic logic [DAC_W-1:0] shape(input logic [DAC_W-1:0] p, input logic [1:0] m);
    logic [DAC_W-2:0] l;
    l = p[DAC_W-2:0];
    case (m)
      2'd0:    shape = {(p[DAC_W-1] ? ~l : l), 1'b0};
      2'd1:    shape = p;
      2'd2:    shape = {DAC_W{p[DAC_W-1]}};
      default: shape = ~p;
    endcase
  endfunction

  // (s - mid) * (amp+1) / 2^AMP_W with floor, re-centred on midscale; cannot overflow.
  function automatic logic [DAC_W-1:0] scale(input logic [DAC_W-1:0] s, input logic [AMP_W-1:0] a);
    logic signed [DAC_W:0]    d;
    logic        [AMP_W:0]    gain;
    logic signed [PROD_W-1:0] prod;
    d    = $signed({1'b0, s} - {1'b0, MID});
    gain = {1'b0, a} + (AMP_W+1)'(1);
    prod = PROD_W'(d) * $signed(PROD_W'(gain));
    scale = MID + DAC_W'(prod >>> AMP_W);
  endfunction

  logic [FREQ_W-1:0] freq_q;
  logic [AMP_W-1:0]  amp_q;
  logic [PH_W-1:0]   ph_q;
  logic [1:0]        mode_q;

  logic [ACC_W-1:0]  acc_p0;
  logic              wf_p0;
  logic [ACC_W:0]    acc_sum;

  assign acc_sum = {1'b0, acc_p0} + {{(ACC_W+1-FREQ_W){1'b0}}, freq_q};

`ifdef WAVE_GEN_SYNC_UPDATE_EN
  logic [FREQ_W-1:0] freq_sh;
  logic [AMP_W-1:0]  amp_sh;
  logic [PH_W-1:0]   ph_sh;
  logic [1:0]        mode_sh;
  logic              pend_q;
  logic              apply;

  // A wrap on the previous edge (or an idle generator) is a safe point to switch settings.
  assign apply = pend_q & (wf_p0 | ~en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freq_sh <= '0;
      amp_sh  <= '1;
      ph_sh   <= '0;
      mode_sh <= '0;
      pend_q  <= 1'b0;
      freq_q  <= '0;
      amp_q   <= '1;
      ph_q    <= '0;
      mode_q  <= '0;
    end else begin
      if (load) begin
        freq_sh <= state_freq;
        amp_sh  <= state_amp;
        ph_sh   <= state_phase;
        mode_sh <= mode;
      end
      if (apply) begin
        freq_q <= freq_sh;
        amp_q  <= amp_sh;
        ph_q   <= ph_sh;
        mode_q <= mode_sh;
      end
      pend_q <= load | (pend_q & ~apply);
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freq_q <= '0;
      amp_q  <= '1;
      ph_q   <= '0;
      mode_q <= '0;
    end else if (load) begin
      freq_q <= state_freq;
      amp_q  <= state_amp;
      ph_q   <= state_phase;
      mode_q <= mode;
    end
  end
`endif

  // Stage 0: phase accumulator, carry-out marks the period boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_p0 <= '0;
      wf_p0  <= 1'b0;
    end else if (en) begin
      {wf_p0, acc_p0} <= acc_sum;
    end else begin
      acc_p0 <= '0;
      wf_p0  <= 1'b0;
    end
  end

  // Stage 1: truncated phase plus left-aligned offset
  logic [DAC_W-1:0] ph_ext;
  logic [DAC_W-1:0] ph_p1;
  logic             vld_p1;
  logic             wrap_p1;

  assign ph_ext = DAC_W'(ph_q) << (DAC_W - PH_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_p1   <= '0;
      vld_p1  <= 1'b0;
      wrap_p1 <= 1'b0;
    end else begin
      ph_p1   <= acc_p0[ACC_W-1 -: DAC_W] + ph_ext;
      vld_p1  <= en;
      wrap_p1 <= wf_p0;
    end
  end

  // Stage 2: waveform shape
  logic [DAC_W-1:0] s_p2;
  logic             vld_p2;
  logic             wrap_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_p2    <= '0;
      vld_p2  <= 1'b0;
      wrap_p2 <= 1'b0;
    end else begin
      s_p2    <= shape(ph_p1, mode_q);
      vld_p2  <= vld_p1;
      wrap_p2 <= wrap_p1;
    end
  end

  // Stage 3: amplitude scaling and DAC register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      DAC_in <= MID;
      sync   <= 1'b0;
    end else begin
      DAC_in <= vld_p2 ? scale(s_p2, amp_q) : MID;
      sync   <= vld_p2 & wrap_p2;
    end
  end

endmodule

// File: tb/tb_wave_gen.sv
// Self-checking bench for wave_gen: directed waveform cases plus randomized settings/enable
// traffic compared against a sample-level reference model.
module tb_wave_gen;

  localparam int DAC_W = 14;
  localparam int ACC_W = 24;
  localparam int FREQ_W = 14;
  localparam int AMP_W = 8;
  localparam int PH_W = 8;
  localparam int DAC_N = 1 << DAC_W;
  localparam int MID = DAC_N / 2;
  localparam longint ACC_N = 64'd1 << ACC_W;
`ifdef WAVE_GEN_SYNC_UPDATE_EN
  localparam int PRE_STEP = 4;
`else
  localparam int PRE_STEP = 8;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              load;
  logic [1:0]        mode;
  logic [FREQ_W-1:0] state_freq;
  logic [AMP_W-1:0]  state_amp;
  logic [PH_W-1:0]   state_phase;
  logic [DAC_W-1:0]  DAC_in;
  logic              sync;

  int errors = 0;
  int checks = 0;

  wave_gen #(.DAC_W(DAC_W), .ACC_W(ACC_W), .FREQ_W(FREQ_W), .AMP_W(AMP_W), .PH_W(PH_W)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .mode(mode),
    .state_freq(state_freq), .state_amp(state_amp), .state_phase(state_phase),
    .DAC_in(DAC_in), .sync(sync)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one record per clock edge holding the phase sampled at that edge and
  // the settings in force; the output after edge k combines the phase from edge k-2, the
  // mode from edge k-1 and the amplitude from edge k.
  typedef struct {
    int ph;
    bit vld;
    bit wrap;
    int mode;
    int amp;
  } rec_t;

  rec_t   pipe[$];
  longint m_acc;
  bit     m_wf;
  int     a_freq, a_amp, a_ph, a_mode;
  int     s_freq, s_amp, s_ph, s_mode;
  bit     pend;
  int     exp_dac;
  bit     exp_sync;

  function automatic int ref_shape(int ph, int m);
    case (m)
      0:       return (ph < MID) ? 2 * ph : 2 * (DAC_N - 1 - ph);
      1:       return ph;
      2:       return (ph >= MID) ? DAC_N - 1 : 0;
      default: return DAC_N - 1 - ph;
    endcase
  endfunction

  function automatic int ref_scale(int s, int amp);
    int num;
    num = (s - MID) * (amp + 1);
    if (num >= 0) return MID + num / (1 << AMP_W);
    return MID - ((-num + (1 << AMP_W) - 1) / (1 << AMP_W));
  endfunction

  task automatic model_reset();
    rec_t r;
    m_acc = 0; m_wf = 0;
    a_freq = 0; a_amp = (1 << AMP_W) - 1; a_ph = 0; a_mode = 0;
    s_freq = a_freq; s_amp = a_amp; s_ph = a_ph; s_mode = a_mode;
    pend = 0;
    r = '{ph: 0, vld: 0, wrap: 0, mode: 0, amp: a_amp};
    pipe.delete();
    repeat (3) pipe.push_back(r);
    exp_dac = MID; exp_sync = 0;
  endtask

  task automatic model_step();
    rec_t   r;
    longint sum;
    bit     old_wf;
    r.ph   = int'(((m_acc >> (ACC_W - DAC_W)) + (longint'(a_ph) << (DAC_W - PH_W))) % DAC_N);
    r.vld  = en;
    r.wrap = m_wf;
    r.mode = a_mode;
    r.amp  = a_amp;
    pipe.push_back(r);
    void'(pipe.pop_front());
    exp_sync = pipe[0].vld && pipe[0].wrap;
    exp_dac  = pipe[0].vld ? ref_scale(ref_shape(pipe[0].ph, pipe[1].mode), pipe[2].amp) : MID;
    old_wf = m_wf;
    if (en) begin
      sum   = m_acc + longint'(a_freq);
      m_wf  = (sum >= ACC_N);
      m_acc = sum % ACC_N;
    end else begin
      m_acc = 0;
      m_wf  = 0;
    end
`ifdef WAVE_GEN_SYNC_UPDATE_EN
    if (pend && (old_wf || !en)) begin
      a_freq = s_freq; a_amp = s_amp; a_ph = s_ph; a_mode = s_mode;
      pend = 0;
    end
    if (load) begin
      s_freq = int'(state_freq); s_amp = int'(state_amp);
      s_ph = int'(state_phase); s_mode = int'(mode);
      pend = 1;
    end
`else
    if (load) begin
      a_freq = int'(state_freq); a_amp = int'(state_amp);
      a_ph = int'(state_phase); a_mode = int'(mode);
    end
`endif
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_eq("dac", 32'(DAC_in), 32'(exp_dac));
    check_eq("sync", 32'(sync), 32'(exp_sync));
    @(negedge clk);
  endtask

  task automatic load_settings(input int m, input int a, input int p, input int f);
    mode = 2'(m); state_amp = AMP_W'(a); state_phase = PH_W'(p); state_freq = FREQ_W'(f);
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
  endtask

  initial begin
    int prev;
    int delta;
    bit found;
    rst = 1'b1; en = 1'b0; load = 1'b0; mode = '0;
    state_freq = '0; state_amp = '0; state_phase = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_dac", 32'(DAC_in), 32'h2000);
    check_eq("reset_sync", 32'(sync), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (3) tick();

    // Sawtooth, full period with wrap and sync
    load_settings(1, 255, 0, 1024);
    en = 1'b1;
    tick(); tick();
    for (int i = 0; i <= 16386; i++) begin
      tick();
      if (i < 3) check_eq("saw_start", 32'(DAC_in), 32'(i));
      if (i == 16383) check_eq("saw_top", 32'(DAC_in), 32'h3FFF);
      if (i == 16384) begin
        check_eq("saw_wrap", 32'(DAC_in), 32'h0);
        check_eq("saw_sync", 32'(sync), 32'h1);
      end
    end

    // Triangle up to and past the peak
    en = 1'b0;
    load_settings(0, 255, 0, 1024);
    en = 1'b1;
    tick(); tick();
    for (int i = 0; i <= 8195; i++) begin
      tick();
      if (i < 3) check_eq("tri_start", 32'(DAC_in), 32'(2 * i));
      if (i == 8191 || i == 8192) check_eq("tri_peak", 32'(DAC_in), 32'h3FFE);
      if (i == 8193) check_eq("tri_down", 32'(DAC_in), 32'h3FFC);
    end

    // Enable drop and restart
    en = 1'b0;
    tick(); tick(); tick();
    check_eq("endrop_mid", 32'(DAC_in), 32'h2000);
    en = 1'b1;
    tick(); tick(); tick();
    check_eq("restart_ph0", 32'(DAC_in), 32'h0);
    tick();
    check_eq("restart_ph1", 32'(DAC_in), 32'h2);

    // Square with half amplitude, without and with phase offset
    en = 1'b0;
    load_settings(2, 127, 0, 1024);
    en = 1'b1;
    tick(); tick(); tick();
    check_eq("sq_low", 32'(DAC_in), 32'h1000);
    en = 1'b0;
    load_settings(2, 127, 8'h80, 1024);
    en = 1'b1;
    tick(); tick(); tick();
    check_eq("sq_phase", 32'(DAC_in), 32'h2FFF);

    // Randomized settings, loads and enable gaps, with one asynchronous reset mid-stream
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 19) != 0);
      load = ($urandom_range(0, 15) == 0);
      mode = 2'($urandom_range(0, 3));
      state_amp = AMP_W'($urandom_range(0, 255));
      state_phase = PH_W'($urandom_range(0, 255));
      state_freq = ($urandom_range(0, 9) == 0) ? '0 : FREQ_W'($urandom_range(1, 16383));
      tick();
      if (i == 1500) begin
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_dac", 32'(DAC_in), 32'h2000);
        check_eq("async_rst_sync", 32'(sync), 32'h0);
        en = 1'b0; load = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
          tick();
          check_eq("post_rst_mid", 32'(DAC_in), 32'h2000);
        end
      end
    end
    load = 1'b0;

    // Frequency change mid-period: deferred to the wrap only with the sync-update build
    en = 1'b0;
    load_settings(1, 255, 0, 4096);
    en = 1'b1;
    tick(); tick();
    repeat (100) tick();
    state_freq = FREQ_W'(8192);
    load = 1'b1;
    tick();
    load = 1'b0;
    repeat (6) tick();
    prev = int'(DAC_in);
    tick();
    delta = (int'(DAC_in) - prev + DAC_N) % DAC_N;
    check_eq("step_pre_wrap", 32'(delta), 32'(PRE_STEP));
    found = 0;
    for (int i = 0; i < 5000 && !found; i++) begin
      tick();
      if (sync) found = 1;
    end
    check_eq("sync_seen", 32'(found), 32'h1);
    tick();
    prev = int'(DAC_in);
    tick();
    delta = (int'(DAC_in) - prev + DAC_N) % DAC_N;
    check_eq("step_post_wrap", 32'(delta), 32'h8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wave_gen.md
# wave_gen

Parametrised multi-mode waveform generator: a phase accumulator drives selectable triangle, sawtooth, square and reverse-sawtooth shapes, with phase offset and amplitude scaling around DAC midscale. Settings are captured on a load strobe and can optionally be applied only at a waveform period boundary. It is the successor of the fixed 14-bit triangle block: it sits between the front-panel state registers and the DAC, and drives the DAC word directly.

## Interface
- DAC_W, 14: DAC word width; output is offset binary, midscale = 2^(DAC_W-1).
- ACC_W, 24: phase accumulator width; must be at least DAC_W and at least FREQ_W.
- FREQ_W, 14: phase increment width.
- AMP_W, 8: amplitude word width.
- PH_W, 8: phase offset width; must be at most DAC_W.

- clk  in  1  system clock; all state on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  generator enable.
- load  in  1  single-cycle strobe that captures the settings inputs.
- mode  in  2  0 triangle, 1 sawtooth, 2 square, 3 reverse sawtooth.
- state_freq  in  FREQ_W  phase increment per clock, zero-extended to ACC_W.
- state_amp  in  AMP_W  amplitude; scale factor = (state_amp+1)/2^AMP_W.
- state_phase  in  PH_W  phase offset, left-aligned onto the DAC_W phase.
- DAC_in  out  DAC_W  registered DAC word.
- sync  out  1  one-cycle pulse on the first sample of each period.

## Operation
- Active settings (freq, amp, phase, mode) are held in registers and change only through load. Reset values: freq 0, amp all-ones, phase 0, mode 0.
- Accumulator: when en=1, acc <= acc + freq mod 2^ACC_W. When en=0, acc <= 0 synchronously. The carry out of this add sets the wrap flag wf for one cycle.
- Stage 1: p1 <= acc[ACC_W-1 -: DAC_W] + (phase << (DAC_W-PH_W)) mod 2^DAC_W; v1 <= en; w1 <= wf.
- Stage 2 shape, with M = p1 MSB and L = p1 lower DAC_W-1 bits:
  - triangle: {M ? ~L : L, 1'b0}
  - sawtooth: p1
  - square: all ones if M, else 0
  - reverse sawtooth: ~p1
  - v2 <= v1; w2 <= w1.
- Stage 3 scale: d = s2 - midscale (signed, DAC_W+1 bits); y = (d*(amp+1)) >>> AMP_W (arithmetic, floor); DAC_in <= v2 ? midscale + y : midscale; sync <= v2 & w2.
- y never overflows. With amp all-ones, DAC_in equals s2 exactly.
- Mode and amp take effect at the pipeline stage that uses them, with no realignment to the sample.

## Timing
- Reset: acc, wf, all pipeline and valid registers 0; DAC_in = midscale (0x2000 at DAC_W=14); sync = 0.
- Reset is asynchronous and may assert at any time. The next output after reset release is midscale until the pipeline refills.
- Latency: en sampled high at edge 0 gives the phase-0 sample on DAC_in after edge 2, then one sample per clock.
- en sampled low at edge k gives DAC_in = midscale after edge k+2. The accumulator restarts at phase 0 when en returns high.
- sync is asserted with the DAC_in sample computed from the first post-wrap accumulator value, which is 3 edges after the wrap edge. The phase offset does not move sync.
- freq = 0 holds the phase; no wrap and no sync occur.

## Configuration
- WAVE_GEN_SYNC_UPDATE_EN defined:
  - load captures the inputs into shadow registers and sets pending.
  - At the next edge with wf set (accumulator wrapped on the previous edge), or on any edge with en=0, the active settings take the shadow values and pending clears.
  - If load coincides with that edge, the new shadow is captured and applied at the following wrap.
  - A repeated load before apply overwrites the shadow.
- Not defined: load copies the inputs straight into the active settings at the edge where load is high. No shadow registers exist.

## Test plan
- Reset: assert rst mid-stream -> DAC_in=0x2000 and sync=0 immediately (asynchronous). After release with en=0, DAC_in stays 0x2000.
- Sawtooth: mode=1, amp=255, phase=0, freq=1024 (ACC_W=24), en rises -> DAC_in 0x0000,0x0001,0x0002,... from the third edge. It wraps 0x3FFF->0x0000 with sync=1 on 0x0000.
- Triangle: same settings, mode=0 -> DAC_in 0,2,4,...,0x3FFE at phase 0x1FFF, then 0x3FFE,0x3FFC,... descending. sync once per 16384 samples.
- Square with amp: mode=2, amp=127, freq=1024 -> DAC_in 0x1000 for the first half-period and 0x2FFF for the second. phase=0x80 -> the first sample is 0x2FFF.
- Enable drop: en low mid-waveform -> DAC_in=0x2000 two edges later. en high again -> the sequence restarts from phase 0 with the standard latency.
- Sync update (macro defined): load freq=2048 mid-period -> increment unchanged until the wrap. The first post-wrap samples step by 2, and sync timing is unaffected. Without the macro, the step changes the cycle after load.
